// File: rtl/cpu_mem_bus_responder.sv
// rtl/cpu_mem_bus_responder.sv - memory-side line responder for the CPU memory bus
// Optional feature macro: CPU_MEMBUS_ERR_EN (adds resp_error for out-of-range addresses)
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

module cpu_mem_bus_responder #(
  parameter int MEM_ADDR_WIDTH = `PHYSICAL_ADDR_WIDTH,
  parameter int LINE_WIDTH     = 128,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]     req_data,
  output logic                      bus_available,
  output logic                      resp_valid,
  output logic [MEM_ADDR_WIDTH-1:0] resp_addr,
`ifdef CPU_MEMBUS_ERR_EN
  output logic                      resp_error,
`endif
  output logic [LINE_WIDTH-1:0]     resp_data
);

  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int IDX = $clog2(DEPTH);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [MEM_ADDR_WIDTH-1:0] OFF_MASK = MEM_ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                    state, state_nx;
  logic [CW-1:0]             cnt;
  logic                      lat_write;
  logic                      lat_err;
  logic [MEM_ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0]     lat_data;
  logic [IDX-1:0]            lat_idx;
  logic                      addr_err;
  logic                      accept;
  logic                      done;
  logic                      commit;
  logic [LINE_WIDTH-1:0]     mem [DEPTH];

`ifdef CPU_MEMBUS_ERR_EN
  assign addr_err   = |req_addr[MEM_ADDR_WIDTH-1:OFF+IDX];
  assign resp_error = (state == S_RESP) & lat_err;
`else
  assign addr_err = 1'b0;
`endif

  assign lat_idx = lat_addr[OFF +: IDX];
  assign commit  = done & lat_write & ~lat_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus_available = 1'b0;
    resp_valid    = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        bus_available = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = lat_write ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      resp_addr <= '0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_err   <= addr_err;
        lat_addr  <= req_addr & ~OFF_MASK;
        lat_data  <= req_data;
        cnt       <= CW'(LATENCY - 1);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Read data is captured on the final WAIT cycle; outputs then hold until the next read.
      if (done && !lat_write) begin
        resp_addr <= lat_addr;
        resp_data <= lat_err ? '0 : mem[lat_idx];
      end
    end
  end

  // Backing store is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (commit) mem[lat_idx] <= lat_data;
  end

endmodule
